ascii_alu_sequencer: RTL and testbench

Keystroke-driven controller that parses an ASCII expression of the form `<digits><operator><digits>=` and sequences the `ascii_alu` datapath. It converts decimal digit bytes into 8-bit operands, maps operator characters onto the ALU's 11-bit one-hot `op_code`, and pulses `go`. It then waits a fixed ALU latency and flags completion to the terminal/VGA layer. It sits between the keyboard/UART byte receiver and the ALU, and drives the ALU's `a`, `b`, `op_code` and `go` inputs directly.

---
 rtl/ascii_alu_sequencer_if.sv | 24 ++
 rtl/ascii_alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_ascii_alu_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_alu_sequencer_if.sv
// Keystroke input handshake plus the registered ALU-facing outputs of the sequencer.
interface ascii_alu_sequencer_if;
    logic [7:0]  key_data;
    logic        key_valid;
    logic        key_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [10:0] op_code;
    logic        go;
    logic        busy;
    logic        result_valid;
    logic        err;
    logic        ovf;

    modport master (
        output key_data, key_valid,
        input  key_ready, a, b, op_code, go, busy, result_valid, err, ovf
    );

    modport slave (
        input  key_data, key_valid,
        output key_ready, a, b, op_code, go, busy, result_valid, err, ovf
    );
endinterface

// File: rtl/ascii_alu_sequencer.sv
// Parses "<digits><op><digits>=" keystrokes into ALU operands and a one-hot op_code,
// pulses go, then waits a fixed ALU latency before flagging result_valid.
module ascii_alu_sequencer #(
    parameter int ALU_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ascii_alu_sequencer_if.slave bus
);
    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_GO   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0] LATENCY  = 8'(ALU_LATENCY);
    localparam logic [7:0] KEY_EQ   = 8'h3D;
    localparam logic [7:0] KEY_ESC  = 8'h1B;

    logic [2:0]  state;
    logic [7:0]  wait_cnt;
    logic        fresh;
    logic        have_digit;

    logic        accept;
    logic        is_digit;
    logic [3:0]  digit_val;
    logic [10:0] op_onehot;
    logic        is_op;
    logic [7:0]  acc_base;
    logic [11:0] acc;

    assign accept = bus.key_valid & bus.key_ready;

    always_comb begin
        is_digit  = (bus.key_data >= 8'h30) && (bus.key_data <= 8'h39);
        digit_val = 4'(bus.key_data - 8'h30);
        op_onehot = '0;
        case (bus.key_data)
            "+":     op_onehot[0]  = 1'b1;
            "-":     op_onehot[1]  = 1'b1;
            "*":     op_onehot[2]  = 1'b1;
            "/":     op_onehot[3]  = 1'b1;
            "%":     op_onehot[4]  = 1'b1;
            "&":     op_onehot[5]  = 1'b1;
            "|":     op_onehot[6]  = 1'b1;
            "^":     op_onehot[7]  = 1'b1;
            "~":     op_onehot[8]  = 1'b1;
            "<":     op_onehot[9]  = 1'b1;
            ">":     op_onehot[10] = 1'b1;
            default: op_onehot     = '0;
        endcase
        is_op = |op_onehot;
        // A fresh digit after a completed op restarts A from zero rather than extending it.
        if (state == S_B)  acc_base = bus.b;
        else if (fresh)    acc_base = 8'd0;
        else               acc_base = bus.a;
        acc = {4'd0, acc_base} * 12'd10 + {8'd0, digit_val};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_A;
            wait_cnt         <= '0;
            fresh            <= 1'b0;
            have_digit       <= 1'b0;
            bus.key_ready    <= 1'b0;
            bus.a            <= '0;
            bus.b            <= '0;
            bus.op_code      <= '0;
            bus.go           <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.err          <= 1'b0;
            bus.ovf          <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all branches see pre-edge values.
            bus.go           <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.err          <= 1'b0;
            case (state)
                S_A, S_B: begin
                    bus.key_ready <= 1'b1;
                    if (accept) begin
                        if (is_digit) begin
                            if (state == S_A && fresh) begin
                                bus.b       <= '0;
                                bus.op_code <= '0;
                                bus.ovf     <= 1'b0;
                                fresh       <= 1'b0;
                            end else if (acc > 12'd255) begin
                                bus.ovf <= 1'b1;
                            end
                            if (state == S_A) bus.a <= acc[7:0];
                            else              bus.b <= acc[7:0];
                            have_digit <= 1'b1;
                        end else if (is_op) begin
                            if (state == S_B || have_digit) begin
                                bus.op_code <= op_onehot;
                                bus.b       <= '0;
                                fresh       <= 1'b0;
                                state       <= S_B;
                            end else begin
                                bus.err <= 1'b1;
                            end
                        end else if (bus.key_data == KEY_EQ) begin
                            if (state == S_B) begin
                                bus.go        <= 1'b1;
                                bus.busy      <= 1'b1;
                                bus.key_ready <= 1'b0;
                                state         <= S_GO;
                            end else begin
                                bus.err <= 1'b1;
                            end
                        end else if (bus.key_data == KEY_ESC) begin
                            bus.a       <= '0;
                            bus.b       <= '0;
                            bus.op_code <= '0;
                            bus.ovf     <= 1'b0;
                            have_digit  <= 1'b0;
                            fresh       <= 1'b0;
                            state       <= S_A;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                S_GO: begin
                    wait_cnt <= LATENCY;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 8'd1) begin
                        bus.result_valid <= 1'b1;
                        state            <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    bus.busy      <= 1'b0;
                    bus.key_ready <= 1'b1;
                    fresh         <= 1'b1;
                    have_digit    <= 1'b1;
                    state         <= S_A;
                end
                default: state <= S_A;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_alu_sequencer.sv
// Directed keystroke bench: a byte-level expression model predicts every output each
// cycle, and literal expectations pin the model on the hand-worked scenarios.
module tb_ascii_alu_sequencer;
    localparam int L = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ascii_alu_sequencer_if ifc ();
    ascii_alu_sequencer #(.ALU_LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(ifc));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expression model: operand values, current operator, and the time of the '=' edge.
    int          m_a, m_b, m_ovf, m_fresh, m_have, m_in_b;
    logic [10:0] m_op;
    int          m_edge = 0, t_eq = 0, pending = 0, started = 0;
    logic        m_rdy = 1'b0, m_go = 1'b0, m_busy = 1'b0, m_rv = 1'b0, m_err = 1'b0;
    string       ops = "+-*/%&|^~<>";

    task automatic model_clear();
        m_a = 0; m_b = 0; m_op = '0; m_ovf = 0; m_fresh = 0; m_have = 0; m_in_b = 0;
    endtask

    task automatic model_byte(input logic [7:0] c);
        int idx, base, t;
        idx = -1;
        for (int i = 0; i < 11; i++) if (ops[i] == c) idx = i;
        if (c >= "0" && c <= "9") begin
            base = m_in_b ? m_b : (m_fresh ? 0 : m_a);
            t = base * 10 + int'(c) - 48;
            if (!m_in_b && m_fresh) begin
                m_b = 0; m_op = '0; m_ovf = 0; m_fresh = 0;
            end
            if (t > 255) m_ovf = 1;
            if (m_in_b) m_b = t % 256; else m_a = t % 256;
            m_have = 1;
        end else if (idx >= 0) begin
            if (m_in_b || m_have) begin
                m_op = 11'(1) << idx; m_b = 0; m_in_b = 1; m_fresh = 0;
            end else m_err = 1'b1;
        end else if (c == "=") begin
            if (m_in_b) begin pending = 1; t_eq = m_edge; end
            else m_err = 1'b1;
        end else if (c == 8'h1B) begin
            model_clear();
        end else m_err = 1'b1;
    endtask

    always @(posedge clk) begin
        int d;
        started = 1;
        m_edge++;
        if (reset) begin
            model_clear();
            pending = 0; m_rdy = 1'b0; m_go = 1'b0; m_busy = 1'b0; m_rv = 1'b0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (ifc.key_valid && m_rdy) model_byte(ifc.key_data);
            m_go = 1'b0; m_busy = 1'b0; m_rv = 1'b0;
            if (pending != 0) begin
                d = m_edge - t_eq;
                m_go   = (d == 0);
                m_busy = (d <= L + 1);
                m_rv   = (d == L + 1);
                if (d == L + 2) begin
                    pending = 0; m_fresh = 1; m_have = 1; m_in_b = 0;
                end
            end
            m_rdy = (pending == 0);
        end
    end

    int go_cnt = 0, rv_cnt = 0, err_cnt = 0, low_cnt = 0;

    always @(negedge clk) begin
        if (started != 0) begin
            check("a", 32'(ifc.a), 32'(m_a));
            check("b", 32'(ifc.b), 32'(m_b));
            check("op_code", 32'(ifc.op_code), 32'(m_op));
            check("ovf", 32'(ifc.ovf), 32'(m_ovf));
            check("key_ready", 32'(ifc.key_ready), 32'(m_rdy));
            check("go", 32'(ifc.go), 32'(m_go));
            check("busy", 32'(ifc.busy), 32'(m_busy));
            check("result_valid", 32'(ifc.result_valid), 32'(m_rv));
            check("err", 32'(ifc.err), 32'(m_err));
            go_cnt  += int'(ifc.go);
            rv_cnt  += int'(ifc.result_valid);
            err_cnt += int'(ifc.err);
            low_cnt += int'(!ifc.key_ready);
        end
    end

    task automatic send(input logic [7:0] c);
        int n;
        @(negedge clk);
        ifc.key_valid = 1'b1;
        ifc.key_data  = c;
        n = 0;
        while (!ifc.key_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'(0));
        @(negedge clk);
        ifc.key_valid = 1'b0;
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!ifc.key_ready || ifc.busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(n), 32'(0));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
    endtask

    int g0, r0, e0, l0;

    initial begin
        ifc.key_valid = 1'b0;
        ifc.key_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 32'(ifc.key_ready), 32'(0));
        check("reset_a", 32'(ifc.a), 32'(0));
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_reset", 32'(ifc.key_ready), 32'(1));

        g0 = go_cnt; r0 = rv_cnt; l0 = low_cnt;
        send_str("12+3=");
        wait_idle();
        check("t1_a", 32'(ifc.a), 32'd12);
        check("t1_b", 32'(ifc.b), 32'd3);
        check("t1_op", 32'(ifc.op_code), 32'(11'b00000000001));
        check("t1_go_count", 32'(go_cnt - g0), 32'd1);
        check("t1_rv_count", 32'(rv_cnt - r0), 32'd1);
        check("t1_ready_low", 32'(low_cnt - l0), 32'd6);

        send_str("300^7=");
        wait_idle();
        check("t2_a", 32'(ifc.a), 32'd44);
        check("t2_ovf", 32'(ifc.ovf), 32'd1);
        check("t2_op", 32'(ifc.op_code), 32'(11'b00010000000));
        check("t2_b", 32'(ifc.b), 32'd7);
        send("5");
        check("t2_fresh_a", 32'(ifc.a), 32'd5);
        check("t2_fresh_b", 32'(ifc.b), 32'd0);
        check("t2_fresh_op", 32'(ifc.op_code), 32'd0);
        check("t2_fresh_ovf", 32'(ifc.ovf), 32'd0);

        do_reset();
        g0 = go_cnt; e0 = err_cnt;
        send_str("+x=");
        #1;
        check("t3_err_count", 32'(err_cnt - e0), 32'd3);
        check("t3_no_go", 32'(go_cnt - g0), 32'd0);
        check("t3_ready", 32'(ifc.key_ready), 32'd1);
        send_str("9~=");
        wait_idle();
        check("t3_a", 32'(ifc.a), 32'd9);
        check("t3_b", 32'(ifc.b), 32'd0);
        check("t3_op", 32'(ifc.op_code), 32'(11'b00100000000));
        check("t3_go", 32'(go_cnt - g0), 32'd1);

        send_str("4-*2=");
        wait_idle();
        check("t4_op", 32'(ifc.op_code), 32'(11'b00000000100));
        check("t4_b", 32'(ifc.b), 32'd2);
        g0 = go_cnt;
        send_str("4|5");
        send(8'h1B);
        check("t4_esc_a", 32'(ifc.a), 32'd0);
        check("t4_esc_b", 32'(ifc.b), 32'd0);
        check("t4_esc_op", 32'(ifc.op_code), 32'd0);
        check("t4_esc_go", 32'(go_cnt - g0), 32'd0);

        send_str("1+1=");
        send("7");
        check("t5_a", 32'(ifc.a), 32'd7);
        check("t5_b", 32'(ifc.b), 32'd0);
        check("t5_op", 32'(ifc.op_code), 32'd0);

        r0 = rv_cnt;
        send_str("2*3=");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t6_a", 32'(ifc.a), 32'd0);
        check("t6_busy", 32'(ifc.busy), 32'd0);
        check("t6_ready", 32'(ifc.key_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("t6_ready_back", 32'(ifc.key_ready), 32'd1);
        repeat (8) @(negedge clk);
        #1;
        check("t6_no_rv", 32'(rv_cnt - r0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
